// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: reads the CDC FIFO once per channel slot and shifts samples out MSB-first with the one-bit WS delay.
// Optional feature I2S_TX_HOLD_LAST_EN: on underrun, replay the channel's last loaded sample instead of muting.
module i2s_tx_serializer #(
  parameter int PKT_WIDTH = 16,
  parameter int RD_LEAD   = 4
) (
  input  logic                 clkI2SBit_i,
  input  logic                 rstI2S_i,
  input  logic [PKT_WIDTH-1:0] pkt_i,
  input  logic                 pktChanged_i,
  output logic                 rdEN_o,
  output logic                 lrclk_o,
  output logic                 sdata_o,
  output logic                 underrun_o
);

  localparam int CW = $clog2(PKT_WIDTH);
  localparam logic [CW-1:0] LAST_CNT   = CW'(PKT_WIDTH - 1);
  localparam logic [CW-1:0] RD_PRE_CNT = CW'(PKT_WIDTH - RD_LEAD - 1);

  logic [CW-1:0]        bitCnt_q, bitCnt_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic                 rdEN_q, rdEN_d;
  logic                 underrun_q, underrun_d;
  logic [PKT_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [PKT_WIDTH-1:0] hold_q, hold_d;
  logic                 holdValid_q, holdValid_d;
  logic                 loadEdge;
  logic                 fresh;
  logic [PKT_WIDTH-1:0] freshPkt;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [PKT_WIDTH-1:0] lastL_q, lastL_d;
  logic [PKT_WIDTH-1:0] lastR_q, lastR_d;
`endif

  always_ff @(posedge clkI2SBit_i or posedge rstI2S_i) begin
    if (rstI2S_i) begin
      bitCnt_q    <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      rdEN_q      <= 1'b0;
      underrun_q  <= 1'b0;
      shiftReg_q  <= '0;
      hold_q      <= '0;
      holdValid_q <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
      lastL_q     <= '0;
      lastR_q     <= '0;
`endif
    end else begin
      bitCnt_q    <= bitCnt_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      rdEN_q      <= rdEN_d;
      underrun_q  <= underrun_d;
      shiftReg_q  <= shiftReg_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
`ifdef I2S_TX_HOLD_LAST_EN
      lastL_q     <= lastL_d;
      lastR_q     <= lastR_d;
`endif
    end
  end

  // A strobe coinciding with the load edge bypasses the hold register.
  always_comb begin
    loadEdge    = (bitCnt_q == LAST_CNT);
    fresh       = pktChanged_i | holdValid_q;
    freshPkt    = pktChanged_i ? pkt_i : hold_q;
    bitCnt_d    = loadEdge ? '0 : bitCnt_q + 1'b1;
    lrclk_d     = lrclk_q ^ loadEdge;
    sdata_d     = shiftReg_q[PKT_WIDTH-1];
    rdEN_d      = (bitCnt_q == RD_PRE_CNT);
    underrun_d  = 1'b0;
    shiftReg_d  = {shiftReg_q[PKT_WIDTH-2:0], 1'b0};
    hold_d      = hold_q;
    holdValid_d = holdValid_q;
`ifdef I2S_TX_HOLD_LAST_EN
    lastL_d     = lastL_q;
    lastR_d     = lastR_q;
`endif
    if (loadEdge) begin
      holdValid_d = 1'b0;
      underrun_d  = ~fresh;
      if (fresh) begin
        shiftReg_d = freshPkt;
`ifdef I2S_TX_HOLD_LAST_EN
        // The slot being loaded is left when the current WS is right.
        if (lrclk_q) lastL_d = freshPkt;
        else         lastR_d = freshPkt;
`endif
      end else begin
`ifdef I2S_TX_HOLD_LAST_EN
        shiftReg_d = lrclk_q ? lastL_q : lastR_q;
`else
        shiftReg_d = '0;
`endif
      end
    end else if (pktChanged_i) begin
      hold_d      = pkt_i;
      holdValid_d = 1'b1;
    end
  end

  assign rdEN_o     = rdEN_q;
  assign lrclk_o    = lrclk_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: a FIFO responder answers rdEN_o, expected slots go to a scoreboard queue.
// Expected underrun fill follows I2S_TX_HOLD_LAST_EN when the same define is given to the bench.
module tb_i2s_tx_serializer;

  localparam int PW   = 16;
  localparam int LEAD = 4;

  logic          clkI2SBit_i = 1'b0;
  logic          rstI2S_i    = 1'b1;
  logic [PW-1:0] pkt_i       = '0;
  logic          pktChanged_i = 1'b0;
  logic          rdEN_o, lrclk_o, sdata_o, underrun_o;

  i2s_tx_serializer #(.PKT_WIDTH(PW), .RD_LEAD(LEAD)) dut (
    .clkI2SBit_i (clkI2SBit_i),
    .rstI2S_i    (rstI2S_i),
    .pkt_i       (pkt_i),
    .pktChanged_i(pktChanged_i),
    .rdEN_o      (rdEN_o),
    .lrclk_o     (lrclk_o),
    .sdata_o     (sdata_o),
    .underrun_o  (underrun_o)
  );

  always #5 clkI2SBit_i = ~clkI2SBit_i;

  typedef struct {
    bit            valid;
    int            d1;
    logic [PW-1:0] v1;
    bit            two;
    int            d2;
    logic [PW-1:0] v2;
  } resp_t;

  typedef struct {
    logic [PW-1:0] w;
    logic          ur;
    logic          lr;
  } exp_t;

  resp_t respQ[$];
  exp_t  expQ[$];

  int total = 0;
  int bad   = 0;
  int cyc, bc, cnt1, cnt2;
  logic [PW-1:0] sv1, sv2;
  logic          modelLr;
  logic [PW-1:0] lastL, lastR;
  logic [PW-1:0] curWord, obsWord;
  logic          curUr, curLr, obsUr, obsLr;
  bit            wordDone;

  task automatic pushResp(input bit valid, input int d1, input logic [PW-1:0] v1,
                          input bit two, input int d2, input logic [PW-1:0] v2);
    resp_t r;
    r.valid = valid; r.d1 = d1; r.v1 = v1; r.two = two; r.d2 = d2; r.v2 = v2;
    respQ.push_back(r);
  endtask

  task automatic assertReset();
    rstI2S_i     = 1'b1;
    pktChanged_i = 1'b0;
    pkt_i        = '0;
    respQ.delete();
    expQ.delete();
    cnt1 = 0; cnt2 = 0;
    modelLr = 1'b1;
    lastL = '0; lastR = '0;
    cyc = 0; bc = 0;
    curWord = '0; curUr = 1'b0; curLr = 1'b0;
    wordDone = 0;
  endtask

  task automatic releaseReset();
    repeat (2) @(negedge clkI2SBit_i);
    rstI2S_i = 1'b0;
    cyc = 0;
  endtask

  // One bit clock: observe at the falling edge, assemble slot words, answer read requests.
  task automatic stepCycle();
    resp_t         r;
    exp_t          e;
    logic [PW-1:0] fin;
    bit            ok;
    @(posedge clkI2SBit_i);
    cyc++;
    @(negedge clkI2SBit_i);
    bc = cyc % PW;
    wordDone = 0;
    if (bc == 0) begin
      if (cyc >= 2 * PW) begin
        obsWord  = {curWord[PW-1:1], sdata_o};
        obsUr    = curUr;
        obsLr    = curLr;
        wordDone = 1;
      end
      curUr   = underrun_o;
      curLr   = lrclk_o;
      curWord = '0;
    end else begin
      curWord[PW-bc] = sdata_o;
    end
    pktChanged_i = 1'b0;
    if (rdEN_o === 1'b1) begin
      ok  = 0;
      fin = '0;
      if (respQ.size() > 0) begin
        r = respQ.pop_front();
        if (r.valid) begin
          ok = 1; cnt1 = r.d1; sv1 = r.v1; fin = r.v1;
          if (r.two) begin cnt2 = r.d2; sv2 = r.v2; fin = r.v2; end
        end
      end
      e.lr = modelLr;
      e.ur = !ok;
`ifdef I2S_TX_HOLD_LAST_EN
      e.w = ok ? fin : (modelLr ? lastR : lastL);
`else
      e.w = ok ? fin : '0;
`endif
      if (ok) begin
        if (modelLr) lastR = fin;
        else         lastL = fin;
      end
      modelLr = !modelLr;
      expQ.push_back(e);
    end
    if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) begin pktChanged_i = 1'b1; pkt_i = sv1; end
    end
    if (cnt2 > 0) begin
      cnt2--;
      if (cnt2 == 0) begin pktChanged_i = 1'b1; pkt_i = sv2; end
    end
  endtask

  task automatic test_reset();
    int firstRd;
    assertReset();
    releaseReset();
    pushResp(1, 2, 16'hFFFF, 0, 0, '0);
    repeat (20) stepCycle();
    assertReset();
    #1;
    total++;
    if ({lrclk_o, sdata_o, rdEN_o, underrun_o} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got lr/sd/rd/ur=%b want 0000", {lrclk_o, sdata_o, rdEN_o, underrun_o});
    end
    releaseReset();
    firstRd = -1;
    for (int i = 0; i < 40 && firstRd < 0; i++) begin
      stepCycle();
      if (rdEN_o === 1'b1) firstRd = cyc;
    end
    total++;
    if (firstRd != PW - LEAD) begin
      bad++;
      $display("[TB] FAIL first_rden: got cycle %0d want %0d", firstRd, PW - LEAD);
    end
  endtask

  task automatic test_single_sample();
    exp_t e;
    assertReset();
    releaseReset();
    pushResp(1, 2, 16'hA5C3, 0, 0, '0);
    for (int i = 0; i < 3 * PW; i++) begin
      stepCycle();
      if (wordDone) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL single_scoreboard: got empty queue want entry");
        end else begin
          e = expQ.pop_front();
          if ({obsWord, obsUr, obsLr} !== {e.w, e.ur, e.lr}) begin
            bad++;
            $display("[TB] FAIL single_slot: got w=%h ur=%b lr=%b want w=%h ur=%b lr=%b",
                     obsWord, obsUr, obsLr, e.w, e.ur, e.lr);
          end
        end
      end
    end
  endtask

  task automatic test_underrun();
    exp_t e;
    assertReset();
    releaseReset();
    pushResp(1, 3, 16'h7E81, 0, 0, '0);
    pushResp(0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 4 * PW; i++) begin
      stepCycle();
      if (wordDone) begin
        total++;
        e = expQ.pop_front();
        if ({obsWord, obsUr, obsLr} !== {e.w, e.ur, e.lr}) begin
          bad++;
          $display("[TB] FAIL underrun_slot: got w=%h ur=%b lr=%b want w=%h ur=%b lr=%b",
                   obsWord, obsUr, obsLr, e.w, e.ur, e.lr);
        end
      end
    end
  endtask

  // Responses use every legal FIFO latency in turn, including the coincident-with-load case.
  task automatic test_streaming();
    exp_t e;
    assertReset();
    releaseReset();
    for (int i = 1; i <= 16; i++) pushResp(1, 1 + (i % 4), 16'(i), 0, 0, '0);
    for (int i = 0; i < 18 * PW; i++) begin
      stepCycle();
      total++;
      if (rdEN_o !== (bc == PW - LEAD) || (bc != 0 && underrun_o !== 1'b0)) begin
        bad++;
        $display("[TB] FAIL stream_pulses: got rd=%b ur=%b at bitCnt %0d want rd=%b ur=0",
                 rdEN_o, underrun_o, bc, (bc == PW - LEAD));
      end
      if (wordDone) begin
        total++;
        e = expQ.pop_front();
        if ({obsWord, obsUr, obsLr} !== {e.w, e.ur, e.lr}) begin
          bad++;
          $display("[TB] FAIL stream_slot: got w=%h ur=%b lr=%b want w=%h ur=%b lr=%b",
                   obsWord, obsUr, obsLr, e.w, e.ur, e.lr);
        end
      end
    end
  endtask

  task automatic test_coincident();
    exp_t e;
    assertReset();
    releaseReset();
    pushResp(1, 4, 16'h8001, 0, 0, '0);
    pushResp(1, 1, 16'h1111, 1, 2, 16'h2222);
    pushResp(1, 1, 16'h3333, 1, 4, 16'h4444);
    for (int i = 0; i < 4 * PW; i++) begin
      stepCycle();
      if (wordDone) begin
        total++;
        e = expQ.pop_front();
        if ({obsWord, obsUr, obsLr} !== {e.w, e.ur, e.lr}) begin
          bad++;
          $display("[TB] FAIL coincident_slot: got w=%h ur=%b lr=%b want w=%h ur=%b lr=%b",
                   obsWord, obsUr, obsLr, e.w, e.ur, e.lr);
        end
      end
    end
  endtask

  task automatic test_hold_last();
    exp_t e;
    assertReset();
    releaseReset();
    pushResp(1, 2, 16'hBEEF, 0, 0, '0);
    pushResp(1, 2, 16'h1234, 0, 0, '0);
    pushResp(1, 3, 16'hC0DE, 0, 0, '0);
    pushResp(0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 6 * PW; i++) begin
      stepCycle();
      if (wordDone) begin
        total++;
        e = expQ.pop_front();
        if ({obsWord, obsUr, obsLr} !== {e.w, e.ur, e.lr}) begin
          bad++;
          $display("[TB] FAIL hold_last_slot: got w=%h ur=%b lr=%b want w=%h ur=%b lr=%b",
                   obsWord, obsUr, obsLr, e.w, e.ur, e.lr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_underrun();
    test_streaming();
    test_coincident();
    test_hold_last();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
